// File: rtl/jk_input_conditioner.sv
// Two-channel push-button conditioner: per-channel synchroniser, debounce
// counter, and registered rise/fall event pulses. Channels share no state.
module jk_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_j,
  input  logic btn_k,
  output logic j_out,
  output logic k_out,
  output logic j_rise,
  output logic j_fall,
  output logic k_rise,
  output logic k_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is J, index 1 is K.
  logic [1:0]                  btn_raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  sync_x;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]                  stable_q, stable_d;
  logic [1:0]                  rise_q, rise_d;
  logic [1:0]                  fall_q, fall_d;

  assign btn_raw = {btn_k, btn_j};

  // Shift chains plus debounce decision for both channels.
  always_comb begin
    sync_d   = sync_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 2'b00;
    fall_d   = 2'b00;
    sync_x   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], btn_raw[c]};
      sync_x[c] = sync_q[c][SYNC_STAGES-1];
      if (sync_x[c] == stable_q[c]) begin
        cnt_d[c] = {CNT_W{1'b0}};
      end else if (cnt_q[c] == CNT_MAX) begin
        // Difference has held long enough: commit and emit the event pulse.
        cnt_d[c]    = {CNT_W{1'b0}};
        stable_d[c] = sync_x[c];
        rise_d[c]   = sync_x[c];
        fall_d[c]   = ~sync_x[c];
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // State registers; reset clears every flop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 2'b00;
      rise_q   <= 2'b00;
      fall_q   <= 2'b00;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign j_out  = stable_q[0];
  assign k_out  = stable_q[1];
  assign j_rise = rise_q[0];
  assign j_fall = fall_q[0];
  assign k_rise = rise_q[1];
  assign k_fall = fall_q[1];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Scoreboard bench: each scenario queues per-cycle stimulus and the
// hand-derived expected output vector {j_out,j_rise,j_fall,k_out,k_rise,k_fall}.
module tb_jk_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_j = 1'b0;
  logic btn_k = 1'b0;
  logic j_out, k_out, j_rise, j_fall, k_rise, k_fall;

  int total = 0;
  int bad   = 0;

  logic [1:0] stim_q[$];
  logic [5:0] exp_q[$];

  localparam logic [5:0] V_IDLE = 6'b000_000;
  localparam logic [5:0] V_J    = 6'b100_000;
  localparam logic [5:0] V_JR   = 6'b110_000;
  localparam logic [5:0] V_JF   = 6'b001_000;
  localparam logic [5:0] V_K    = 6'b000_100;
  localparam logic [5:0] V_KR   = 6'b000_110;
  localparam logic [5:0] V_KF   = 6'b000_001;
  localparam logic [5:0] V_JK   = 6'b100_100;
  localparam logic [5:0] V_JKR  = 6'b110_110;
  localparam logic [5:0] V_JKF  = 6'b001_001;

  jk_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_j(btn_j), .btn_k(btn_k),
    .j_out(j_out), .k_out(k_out),
    .j_rise(j_rise), .j_fall(j_fall), .k_rise(k_rise), .k_fall(k_fall)
  );

  always #5 clk = ~clk;

  task automatic push_stim(input int n, input logic j, input logic k);
    for (int i = 0; i < n; i++) stim_q.push_back({j, k});
  endtask

  task automatic push_exp(input int n, input logic [5:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Drive one queued input pair before the edge, sample #1 after it.
  task automatic run_cycle(output logic [5:0] got, output logic [5:0] want);
    logic [1:0] s;
    s = stim_q.pop_front();
    btn_j = s[1];
    btn_k = s[0];
    @(posedge clk);
    #1;
    got  = {j_out, j_rise, j_fall, k_out, k_rise, k_fall};
    want = exp_q.pop_front();
  endtask

  function automatic logic [5:0] outs();
    return {j_out, j_rise, j_fall, k_out, k_rise, k_fall};
  endfunction

  task automatic test_reset;
    logic [5:0] got, want;
    #20;
    total++;
    if (outs() !== V_IDLE) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", outs(), V_IDLE);
    end
    rst = 1'b0;
    push_stim(8, 1'b1, 1'b0);
    push_exp(5, V_IDLE);
    push_exp(1, V_JR);
    push_exp(2, V_J);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL clean_press E%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  task automatic test_release;
    logic [5:0] got, want;
    push_stim(8, 1'b0, 1'b0);
    push_exp(5, V_J);
    push_exp(1, V_JF);
    push_exp(2, V_IDLE);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL release E%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  task automatic test_glitch;
    logic [5:0] got, want;
    push_stim(3, 1'b0, 1'b1);
    push_stim(20, 1'b0, 1'b0);
    push_exp(23, V_IDLE);
    push_stim(4, 1'b0, 1'b1);
    push_stim(12, 1'b0, 1'b0);
    push_exp(5, V_IDLE);
    push_exp(1, V_KR);
    push_exp(3, V_K);
    push_exp(1, V_KF);
    push_exp(6, V_IDLE);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL glitch_k C%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  task automatic test_bounce;
    logic [5:0] got, want;
    push_stim(1, 1'b1, 1'b0);
    push_stim(1, 1'b0, 1'b0);
    push_stim(1, 1'b1, 1'b0);
    push_stim(1, 1'b0, 1'b0);
    push_stim(8, 1'b1, 1'b0);
    push_exp(9, V_IDLE);
    push_exp(1, V_JR);
    push_exp(2, V_J);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bounce_j E%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] got, want;
    push_stim(8, 1'b1, 1'b1);
    push_exp(5, V_IDLE);
    push_exp(1, V_JKR);
    push_exp(2, V_JK);
    push_stim(8, 1'b0, 1'b0);
    push_exp(5, V_JK);
    push_exp(1, V_JKF);
    push_exp(2, V_IDLE);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL simultaneous C%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] got, want;
    push_stim(4, 1'b1, 1'b0);
    push_exp(4, V_IDLE);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pre_reset E%0d got=%b exp=%b", e, got, want);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== V_IDLE) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", outs(), V_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (outs() !== V_IDLE) begin
        bad++;
        $display("FAIL reset_held C%0d got=%b exp=%b", i, outs(), V_IDLE);
      end
    end
    rst = 1'b0;
    push_stim(8, 1'b1, 1'b0);
    push_exp(5, V_IDLE);
    push_exp(1, V_JR);
    push_exp(2, V_J);
    for (int e = 1; exp_q.size() != 0; e++) begin
      run_cycle(got, want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL post_reset E%0d got=%b exp=%b", e, got, want);
      end
    end
  endtask

  initial begin
    test_reset;
    test_release;
    test_glitch;
    test_bounce;
    test_release;
    test_simultaneous;
    test_reset_mid;
    test_release;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
